// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
// Bundles the signals between the RX shifter / consumer and the receive FIFO.
//   done, output_data       : frame-complete strobe and byte from the RX shifter
//   rd_en, clr_overrun      : pop request and overrun-flag clear from the consumer
//   rd_data, rd_valid       : head byte and its qualifier
//   empty, full, count      : occupancy status (registered-pointer derived)
//   overrun                 : sticky dropped-byte flag
// Modports: master = shifter/consumer side, slave = FIFO side.
interface uart_rx_fifo_if #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 8
);
   logic                    done;
   logic [DATA_W-1:0]       output_data;
   logic                    rd_en;
   logic                    clr_overrun;
   logic [DATA_W-1:0]       rd_data;
   logic                    rd_valid;
   logic                    empty;
   logic                    full;
   logic [$clog2(DEPTH):0]  count;
   logic                    overrun;

   modport master (
      output done, output_data, rd_en, clr_overrun,
      input  rd_data, rd_valid, empty, full, count, overrun
   );

   modport slave (
      input  done, output_data, rd_en, clr_overrun,
      output rd_data, rd_valid, empty, full, count, overrun
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive byte buffer behind the UART RX shifter. One byte is captured per
// rising edge of done, stored in a circular FIFO and popped by the consumer.
// A byte arriving while full (and not relieved by a same-cycle pop) is
// dropped and sets the sticky overrun flag.
// Ports:
//   clk    : system clock (shared with the RX shifter)
//   reset  : asynchronous, active-low reset
//   bus    : uart_rx_fifo_if.slave (write strobe/data, pop, status, overrun)
// Build option:
//   UART_RX_FIFO_FWFT_EN defined -> first-word-fall-through read (rd_data shows
//   the head combinationally, rd_valid = ~empty). Undefined (default) ->
//   registered read: a pop loads rd_data and pulses rd_valid for one cycle.
module uart_rx_fifo #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 8
) (
   input  logic           clk,
   input  logic           reset,
   uart_rx_fifo_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic              done_q;
   logic              overrun_q;
   logic              wr;
   logic              pop;
   logic              push;
   logic              drop;
   logic              empty_i;
   logic              full_i;

   assign wr      = bus.done & ~done_q;
   assign empty_i = (wr_ptr == rd_ptr);
   assign full_i  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign pop     = bus.rd_en & ~empty_i;
   // A pop in the same cycle frees the slot being written, so full is no obstacle.
   assign push    = wr & (~full_i | pop);
   assign drop    = wr & full_i & ~pop;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         done_q <= bus.done;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (drop)
            overrun_q <= 1'b1;
         else if (bus.clr_overrun)
            overrun_q <= 1'b0;
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= bus.output_data;
   end

`ifdef UART_RX_FIFO_FWFT_EN
   assign bus.rd_data  = mem[rd_ptr[AW-1:0]];
   assign bus.rd_valid = ~empty_i;
`else
   logic [DATA_W-1:0] rd_data_q;
   logic              rd_valid_q;

   // When full with a coincident write, the written slot is the one being
   // read; the non-blocking read returns the old (head) byte, as intended.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= pop;
         if (pop) rd_data_q <= mem[rd_ptr[AW-1:0]];
      end
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
`endif

   assign bus.empty   = empty_i;
   assign bus.full    = full_i;
   assign bus.count   = wr_ptr - rd_ptr;
   assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
// Randomized and directed stimulus for uart_rx_fifo, checked against a
// queue-based reference model of the receive buffer.
module tb_uart_rx_fifo;
   localparam int DEPTH  = 16;
   localparam int DATA_W = 8;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   uart_rx_fifo_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

   uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state
   logic [DATA_W-1:0] q [$];
   bit                m_done_q;
   bit                m_ov;
   bit                m_rv;
   logic [DATA_W-1:0] m_rd;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_done_q = 1'b0;
      m_ov     = 1'b0;
      m_rv     = 1'b0;
      m_rd     = '0;
   endtask

   task automatic check_outputs();
      chk("count", 32'(bus.count), 32'(q.size()));
      chk("empty", 32'(bus.empty), 32'(q.size() == 0));
      chk("full", 32'(bus.full), 32'(q.size() == DEPTH));
      chk("overrun", 32'(bus.overrun), 32'(m_ov));
`ifdef UART_RX_FIFO_FWFT_EN
      chk("rd_valid", 32'(bus.rd_valid), 32'(q.size() != 0));
      if (q.size() != 0) chk("rd_data", 32'(bus.rd_data), 32'(q[0]));
`else
      chk("rd_valid", 32'(bus.rd_valid), 32'(m_rv));
      chk("rd_data", 32'(bus.rd_data), 32'(m_rd));
`endif
   endtask

   // Apply current inputs for one clock edge, advance the model, then check.
   task automatic step();
      bit                wr;
      bit                pop;
      bit                drop;
      logic [DATA_W-1:0] pv;
      wr   = bus.done && !m_done_q;
      pop  = bus.rd_en && (q.size() != 0);
      drop = 1'b0;
      pv   = '0;
      if (pop) pv = q.pop_front();
      if (wr) begin
         if (q.size() < DEPTH) q.push_back(bus.output_data);
         else drop = 1'b1;
      end
      if (drop) m_ov = 1'b1;
      else if (bus.clr_overrun) m_ov = 1'b0;
      m_rv = pop;
      if (pop) m_rd = pv;
      m_done_q = bus.done;
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle_inputs();
      bus.done        = 1'b0;
      bus.rd_en       = 1'b0;
      bus.clr_overrun = 1'b0;
   endtask

   // One frame: done high for 'hold' cycles, then one low cycle.
   task automatic frame(input logic [DATA_W-1:0] b, input int hold);
      bus.output_data = b;
      bus.done        = 1'b1;
      for (int i = 0; i < hold; i++) step();
      bus.done = 1'b0;
      step();
   endtask

   task automatic drain();
      bus.rd_en = 1'b1;
      for (int i = 0; i < DEPTH + 2; i++) step();
      bus.rd_en = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_empty"}, 32'(bus.empty), 32'd1);
      chk({tag, "_full"}, 32'(bus.full), 32'd0);
      chk({tag, "_count"}, 32'(bus.count), 32'd0);
      chk({tag, "_overrun"}, 32'(bus.overrun), 32'd0);
      chk({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'd0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      bus.output_data = '0;
      idle_inputs();
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_state("por");
      reset = 1'b1;
      @(negedge clk);

      // single byte with a long done
      bus.output_data = 8'hA5;
      bus.done = 1'b1;
      for (int i = 0; i < 16; i++) step();
      bus.done = 1'b0;
      step();
      chk("long_done_count", 32'(bus.count), 32'd1);
      bus.rd_en = 1'b1;
      step();
      bus.rd_en = 1'b0;
`ifndef UART_RX_FIFO_FWFT_EN
      chk("single_rd_data", 32'(bus.rd_data), 32'hA5);
      chk("single_rd_valid", 32'(bus.rd_valid), 32'd1);
`endif
      step();
      chk("single_empty", 32'(bus.empty), 32'd1);

      // fill past capacity
      for (int i = 0; i < 17; i++) frame(8'(i), 2);
      chk("fill_full", 32'(bus.full), 32'd1);
      chk("fill_count", 32'(bus.count), 32'd16);
      chk("fill_overrun", 32'(bus.overrun), 32'd1);
      drain();

      // full with coincident pop and write
      bus.clr_overrun = 1'b1;
      step();
      bus.clr_overrun = 1'b0;
      for (int i = 0; i < DEPTH; i++) frame(8'(8'h40 + i), 1);
      bus.output_data = 8'h5A;
      bus.done  = 1'b1;
      bus.rd_en = 1'b1;
      step();
      idle_inputs();
      chk("simul_count", 32'(bus.count), 32'd16);
      chk("simul_overrun", 32'(bus.overrun), 32'd0);
      bus.rd_en = 1'b1;
      for (int i = 0; i < DEPTH - 1; i++) step();
`ifdef UART_RX_FIFO_FWFT_EN
      chk("simul_last", 32'(bus.rd_data), 32'h5A);
      step();
`else
      step();
      chk("simul_last", 32'(bus.rd_data), 32'h5A);
`endif
      bus.rd_en = 1'b0;
      step();

      // wrap-around streaming
      bus.rd_en = 1'b1;
      for (int i = 0; i < 40; i++) begin
         bus.output_data = 8'(i);
         bus.done = 1'b1;
         step();
         chk("wrap_cnt_le2", 32'(bus.count <= 2), 32'd1);
         bus.done = 1'b0;
         step();
         chk("wrap_cnt_le2", 32'(bus.count <= 2), 32'd1);
      end
      step();
      step();
      bus.rd_en = 1'b0;
      chk("wrap_overrun", 32'(bus.overrun), 32'd0);

      // pop while empty
      bus.rd_en = 1'b1;
      step();
      bus.rd_en = 1'b0;
      chk("empty_pop_count", 32'(bus.count), 32'd0);
      chk("empty_pop_valid", 32'(bus.rd_valid), 32'd0);

      // clear coincident with drop, then lone clear
      for (int i = 0; i < DEPTH; i++) frame(8'($urandom), 1);
      bus.output_data = 8'hEE;
      bus.done = 1'b1;
      bus.clr_overrun = 1'b1;
      step();
      idle_inputs();
      chk("clr_vs_drop", 32'(bus.overrun), 32'd1);
      bus.clr_overrun = 1'b1;
      step();
      bus.clr_overrun = 1'b0;
      chk("lone_clr", 32'(bus.overrun), 32'd0);

      // reset mid-frame with done held high through release
      bus.output_data = 8'h77;
      bus.done  = 1'b1;
      bus.rd_en = 1'b1;
      step();
      #2 reset = 1'b0;
      #1 check_reset_state("mid");
      model_reset();
      bus.rd_en = 1'b0;
      @(negedge clk);
      bus.output_data = 8'h3C;
      reset = 1'b1;
      step();
      chk("post_rst_count", 32'(bus.count), 32'd1);
      bus.done = 1'b0;
      drain();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bus.done        = ($urandom_range(0, 2) != 0) ? ~bus.done : bus.done;
         bus.output_data = 8'($urandom);
         bus.rd_en       = ($urandom_range(0, 3) == 0);
         bus.clr_overrun = ($urandom_range(0, 15) == 0);
         step();
      end
      idle_inputs();
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout t=%0t", $time);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART RX shifter (`shift_top`). It captures each completed frame byte on the rising edge of the shifter's `done`, stores it in a circular FIFO, and presents it to the LSU/bus side through a pop handshake. It also keeps a sticky overrun flag for bytes dropped while the FIFO is full.

## Interface
Parameters:
- `DEPTH`, default 16: number of entries; power of two, ≥ 2.
- `DATA_W`, default 8: byte width; matches the shifter's `output_data`.

Ports:
- `clk`  in  1  system clock; the same clock the RX shifter runs on.
- `reset`  in  1  reset, asynchronous and active-low.
- `done`  in  1  shifter frame-complete; may stay high for several cycles.
- `output_data`  in  DATA_W  shifter byte; valid while `done`=1.
- `rd_en`  in  1  pop request from the consumer.
- `clr_overrun`  in  1  synchronous clear of `overrun`.
- `rd_data`  out  DATA_W  head byte; see Configuration.
- `rd_valid`  out  1  `rd_data` qualifier.
- `empty`  out  1  no entries stored.
- `full`  out  1  DEPTH entries stored.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overrun`  out  1  sticky: a byte was dropped.

## Operation
- Write detect: `done` is registered into `done_q`. The write strobe is `wr = done & ~done_q`, so one write happens per frame regardless of how long `done` stays high.
- Pointers: `wr_ptr` and `rd_ptr` are $clog2(DEPTH)+1 bits wide, with an extra wrap bit. Storage is indexed by the low bits.
  - `empty` = pointers equal.
  - `full` = low bits equal and MSBs differ.
  - `count` = `wr_ptr - rd_ptr`, modulo 2^(width).
- Write:
  - If `wr` and not full, `mem[wr_ptr]` ← `output_data` and `wr_ptr` increments.
  - If `wr` while full and no pop happens that cycle, the byte is dropped and `overrun` is set.
- Pop: if `rd_en` and not empty, `rd_ptr` increments. `rd_en` while empty is ignored and has no side effect.
- Simultaneous `wr` and pop:
  - Not empty: both take effect and `count` is unchanged.
  - Full: both take effect, no drop, and `overrun` is not set.
  - Empty: the write takes effect and the pop is ignored.
- Overrun:
  - `clr_overrun` clears the flag.
  - If `clr_overrun` and a new drop occur in the same cycle, set wins.
- Wrap-around: pointers roll over modulo 2·DEPTH with no special handling.
- Reset (asserted at any time, including mid-frame or mid-pop) clears:
  - pointers, `done_q`, `overrun`, `rd_data`, `rd_valid`
  - → `empty`=1, `full`=0, `count`=0
  - Memory contents are not cleared.
  - If `done` is already high at deassertion, the next edge counts as a write because `done_q`=0.

## Timing
- Write latency: a `done` rise sampled at edge N is stored at edge N. `empty`, `count` and `full` reflect it after edge N.
- The earliest readable cycle is N+1 (FWFT mode) or a pop issued at N+1 (registered mode).
- Status outputs are all derived from registered pointers; there is no combinational path from inputs to `empty`, `full` or `count`.
- The pop handshake has no backpressure beyond `empty`; the consumer must qualify `rd_en` with `~empty`.

## Configuration
Macro: `UART_RX_FIFO_FWFT_EN`.

With `UART_RX_FIFO_FWFT_EN` defined (first-word-fall-through):
- `rd_data` = `mem[rd_ptr]` combinationally.
- `rd_valid` = `~empty`.
- `rd_en` acknowledges the byte currently shown; 0-cycle read latency.

Without the macro (registered read, the default):
- A pop at edge N loads `rd_data` ← `mem[rd_ptr]` at edge N.
- `rd_valid` pulses high for exactly the cycle after N.
- `rd_data` holds its value until the next successful pop.
- 1-cycle read latency.

## Test plan
- **Reset state**: assert `reset`=0 mid-stream → `empty`=1, `full`=0, `count`=0, `overrun`=0, `rd_valid`=0. After release, the FIFO accepts a new byte normally.
- **Single byte, long `done`**: drive `output_data`=8'hA5 with `done` high for 16 cycles → `count`=1, not 16. Pop → `rd_data`=8'hA5, with `rd_valid` per mode, then `empty`=1.
- **Fill and overrun**: write 17 bytes 0x00..0x10 with DEPTH=16 → `full`=1, `count`=16, `overrun`=1. Draining returns 0x00..0x0F in order; 0x10 is lost.
- **Simultaneous wr/rd when full**: with the FIFO full, pop and write 8'h5A in the same cycle → `count` stays 16, `overrun` stays 0, and 8'h5A is read last.
- **Wrap-around**: stream 40 bytes 0..39 while popping continuously → output order 0..39, `count` never exceeds 2, `overrun`=0.
- **Empty pop and overrun clear**: `rd_en` while empty → pointers and `rd_valid` unchanged. `clr_overrun` coincident with a drop → `overrun` remains 1. A lone `clr_overrun` → 0.
